// File: rtl/memory_stage.sv
// Pipeline M stage: word loads/stores over a req/ack bus, M/W register,
// misalignment and bus-timeout error reporting.
module memory_stage #(
  parameter int WIDTH    = 32,
  parameter int REG_ADDR = 5,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                validM,
  input  logic [WIDTH-1:0]    ALUResultM,
  input  logic [WIDTH-1:0]    writeDataM,
  input  logic [WIDTH-1:0]    pcM,
  input  logic [REG_ADDR-1:0] writeRegM,
  input  logic                regWriteM,
  input  logic                memWriteM,
  input  logic                mem2regM,
  output logic                stallM,
  output logic                dreq,
  output logic                dwe,
  output logic [WIDTH-1:0]    daddr,
  output logic [WIDTH-1:0]    dwdata,
  input  logic                dack,
  input  logic [WIDTH-1:0]    drdata,
  output logic [WIDTH-1:0]    resultW,
  output logic [WIDTH-1:0]    pcW,
  output logic [REG_ADDR-1:0] writeRegW,
  output logic                regWriteW,
  output logic                validW,
  output logic                errW
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUS  = 1'b1;
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  logic [0:0]          state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                dreq_q, dreq_d;
  logic                dwe_q, dwe_d;
  logic [WIDTH-1:0]    daddr_q, daddr_d;
  logic [WIDTH-1:0]    dwdata_q, dwdata_d;
  // Copy of the memory op's writeback info, held while the bus is busy
  logic [WIDTH-1:0]    lpc_q, lpc_d;
  logic [REG_ADDR-1:0] lwreg_q, lwreg_d;
  logic                lrw_q, lrw_d;
  logic                lload_q, lload_d;
  // M/W pipeline register
  logic [WIDTH-1:0]    result_w_q, result_w_d;
  logic [WIDTH-1:0]    pc_w_q, pc_w_d;
  logic [REG_ADDR-1:0] wreg_w_q, wreg_w_d;
  logic                rw_w_q, rw_w_d;
  logic                valid_w_q, valid_w_d;
  logic                err_w_q, err_w_d;
  logic                stall;

  logic mem_op, misaligned;
  assign mem_op     = validM & (memWriteM | mem2regM);
  assign misaligned = ALUResultM[1:0] != 2'b00;

  // Next-state, bus and W-slot decode; W defaults to a bubble every cycle
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dreq_d     = dreq_q;
    dwe_d      = dwe_q;
    daddr_d    = daddr_q;
    dwdata_d   = dwdata_q;
    lpc_d      = lpc_q;
    lwreg_d    = lwreg_q;
    lrw_d      = lrw_q;
    lload_d    = lload_q;
    result_w_d = '0;
    pc_w_d     = pc_w_q;
    wreg_w_d   = wreg_w_q;
    rw_w_d     = 1'b0;
    valid_w_d  = 1'b0;
    err_w_d    = 1'b0;
    stall      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (validM && !mem_op) begin
          result_w_d = ALUResultM;
          pc_w_d     = pcM;
          wreg_w_d   = writeRegM;
          rw_w_d     = regWriteM;
          valid_w_d  = 1'b1;
        end else if (mem_op && misaligned) begin
          pc_w_d    = pcM;
          wreg_w_d  = writeRegM;
          valid_w_d = 1'b1;
          err_w_d   = 1'b1;
        end else if (mem_op) begin
          stall    = 1'b1;
          dreq_d   = 1'b1;
          dwe_d    = memWriteM;
          daddr_d  = ALUResultM;
          dwdata_d = writeDataM;
          lpc_d    = pcM;
          lwreg_d  = writeRegM;
          lrw_d    = regWriteM;
          lload_d  = mem2regM;
          cnt_d    = '0;
          state_d  = S_BUS;
        end
      end
      default: begin
        // dack takes priority over the timeout on the same cycle
        if (dack) begin
          dreq_d     = 1'b0;
          state_d    = S_IDLE;
          result_w_d = lload_q ? drdata : '0;
          pc_w_d     = lpc_q;
          wreg_w_d   = lwreg_q;
          rw_w_d     = lrw_q & lload_q;
          valid_w_d  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          dreq_d    = 1'b0;
          state_d   = S_IDLE;
          pc_w_d    = lpc_q;
          wreg_w_d  = lwreg_q;
          valid_w_d = 1'b1;
          err_w_d   = 1'b1;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + 16'd1;
        end
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dreq_q     <= 1'b0;
      dwe_q      <= 1'b0;
      daddr_q    <= '0;
      dwdata_q   <= '0;
      lpc_q      <= '0;
      lwreg_q    <= '0;
      lrw_q      <= 1'b0;
      lload_q    <= 1'b0;
      result_w_q <= '0;
      pc_w_q     <= '0;
      wreg_w_q   <= '0;
      rw_w_q     <= 1'b0;
      valid_w_q  <= 1'b0;
      err_w_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dreq_q     <= dreq_d;
      dwe_q      <= dwe_d;
      daddr_q    <= daddr_d;
      dwdata_q   <= dwdata_d;
      lpc_q      <= lpc_d;
      lwreg_q    <= lwreg_d;
      lrw_q      <= lrw_d;
      lload_q    <= lload_d;
      result_w_q <= result_w_d;
      pc_w_q     <= pc_w_d;
      wreg_w_q   <= wreg_w_d;
      rw_w_q     <= rw_w_d;
      valid_w_q  <= valid_w_d;
      err_w_q    <= err_w_d;
    end
  end

  assign stallM    = stall;
  assign dreq      = dreq_q;
  assign dwe       = dwe_q;
  assign daddr     = daddr_q;
  assign dwdata    = dwdata_q;
  assign resultW   = result_w_q;
  assign pcW       = pc_w_q;
  assign writeRegW = wreg_w_q;
  assign regWriteW = rw_w_q;
  assign validW    = valid_w_q;
  assign errW      = err_w_q;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: stimulus pushes expected W results,
// a negedge monitor pops and compares whenever validW is seen.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        validM, regWriteM, memWriteM, mem2regM;
  logic [31:0] ALUResultM, writeDataM, pcM;
  logic [4:0]  writeRegM;
  logic        stallM, dreq, dwe, dack;
  logic [31:0] daddr, dwdata, drdata, resultW, pcW;
  logic [4:0]  writeRegW;
  logic        regWriteW, validW, errW;

  memory_stage #(.WIDTH(32), .REG_ADDR(5), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .validM(validM), .ALUResultM(ALUResultM),
    .writeDataM(writeDataM), .pcM(pcM), .writeRegM(writeRegM),
    .regWriteM(regWriteM), .memWriteM(memWriteM), .mem2regM(mem2regM),
    .stallM(stallM), .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata),
    .dack(dack), .drdata(drdata), .resultW(resultW), .pcW(pcW),
    .writeRegW(writeRegW), .regWriteW(regWriteW), .validW(validW), .errW(errW)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] pc;
    logic [4:0]  wr;
    logic        rw;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [31:0] pc, input logic [4:0] wr, input logic rw,
                       input logic mw, input logic m2r);
    validM = v; ALUResultM = alu; writeDataM = wd; pcM = pc;
    writeRegM = wr; regWriteM = rw; memWriteM = mw; mem2regM = m2r;
  endtask

  task automatic bubble();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [31:0] res, input logic [31:0] pc, input logic [4:0] wr,
                      input logic rw, input logic err);
    exp_t e;
    e.res = res; e.pc = pc; e.wr = wr; e.rw = rw; e.err = err;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every W instruction against the scoreboard head
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && !reset) begin
      if (validW === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL w_unexpected: got validW=1 pc=%h expected no instruction", pcW);
        end else begin
          e = exp_q.pop_front();
          chk("w_result",   resultW,           e.res);
          chk("w_pc",       pcW,               e.pc);
          chk("w_writereg", {27'd0, writeRegW}, {27'd0, e.wr});
          chk("w_regwrite", {31'd0, regWriteW}, {31'd0, e.rw});
          chk("w_err",      {31'd0, errW},      {31'd0, e.err});
        end
      end else begin
        chk("w_bubble_ctl", {30'd0, regWriteW, errW}, 32'd0);
      end
    end
  end

  initial begin
    reset = 1'b1; dack = 1'b0; drdata = 32'h0;
    bubble();
    tick(); tick();
    // Reset state
    chk("rst_dreq",   {31'd0, dreq},   32'd0);
    chk("rst_dwe",    {31'd0, dwe},    32'd0);
    chk("rst_daddr",  daddr,           32'd0);
    chk("rst_validW", {31'd0, validW}, 32'd0);
    chk("rst_result", resultW,         32'd0);
    reset = 1'b0;
    mon_en = 1'b1;

    // 1: ALU op, one-cycle latency
    drive(1'b1, 32'h10, 32'h0, 32'h1000, 5'd5, 1'b1, 1'b0, 1'b0);
    #1 chk("alu_stall", {31'd0, stallM}, 32'd0);
    push(32'h10, 32'h1000, 5'd5, 1'b1, 1'b0);
    tick();
    bubble();

    // 2: aligned load, ack on third BUS cycle
    drive(1'b1, 32'h100, 32'h0, 32'h1004, 5'd7, 1'b1, 1'b0, 1'b1);
    #1 chk("ld_stall_idle", {31'd0, stallM}, 32'd1);
    tick();
    chk("ld_dreq",  {31'd0, dreq},   32'd1);
    chk("ld_daddr", daddr,           32'h100);
    chk("ld_dwe",   {31'd0, dwe},    32'd0);
    chk("ld_stall_b0", {31'd0, stallM}, 32'd1);
    tick();
    chk("ld_stall_b1", {31'd0, stallM}, 32'd1);
    chk("ld_dreq_b1",  {31'd0, dreq},   32'd1);
    tick();
    dack = 1'b1; drdata = 32'hDEADBEEF;
    #1 chk("ld_stall_ack", {31'd0, stallM}, 32'd0);
    push(32'hDEADBEEF, 32'h1004, 5'd7, 1'b1, 1'b0);
    tick();
    dack = 1'b0; drdata = 32'h0;
    chk("ld_dreq_drop", {31'd0, dreq}, 32'd0);

    // 3: store, ack on first BUS cycle; regWrite forced off in W
    drive(1'b1, 32'h200, 32'h12345678, 32'h1008, 5'd9, 1'b1, 1'b1, 1'b0);
    #1 chk("st_stall_idle", {31'd0, stallM}, 32'd1);
    tick();
    chk("st_dwe",    {31'd0, dwe}, 32'd1);
    chk("st_dwdata", dwdata,       32'h12345678);
    chk("st_daddr",  daddr,        32'h200);
    dack = 1'b1;
    #1 chk("st_stall_ack", {31'd0, stallM}, 32'd0);
    push(32'h0, 32'h1008, 5'd9, 1'b0, 1'b0);
    tick();
    dack = 1'b0;

    // 4: back-to-back misaligned load, no bus access
    drive(1'b1, 32'h102, 32'h0, 32'h100C, 5'd3, 1'b1, 1'b0, 1'b1);
    #1 chk("mis_stall", {31'd0, stallM}, 32'd0);
    push(32'h0, 32'h100C, 5'd3, 1'b0, 1'b1);
    tick();
    bubble();
    chk("mis_dreq", {31'd0, dreq}, 32'd0);

    // 5: load with no ack times out after 4 BUS cycles
    drive(1'b1, 32'h300, 32'h0, 32'h1010, 5'd4, 1'b1, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("to_dreq",  {31'd0, dreq},   32'd1);
      chk("to_stall", {31'd0, stallM}, 32'd1);
      tick();
    end
    chk("to_dreq_last",  {31'd0, dreq},   32'd1);
    chk("to_stall_last", {31'd0, stallM}, 32'd0);
    push(32'h0, 32'h1010, 5'd4, 1'b0, 1'b1);
    tick();
    bubble();
    chk("to_dreq_drop", {31'd0, dreq}, 32'd0);
    dack = 1'b1; drdata = 32'hBAD0BAD0;
    tick();
    dack = 1'b0;
    chk("stray_dreq", {31'd0, dreq}, 32'd0);
    tick();

    // Boundary: ack on the last BUS cycle beats the timeout
    drive(1'b1, 32'h400, 32'h0, 32'h1014, 5'd11, 1'b1, 1'b0, 1'b1);
    tick(); tick(); tick(); tick();
    dack = 1'b1; drdata = 32'hCAFEF00D;
    #1 chk("race_stall", {31'd0, stallM}, 32'd0);
    push(32'hCAFEF00D, 32'h1014, 5'd11, 1'b1, 1'b0);
    tick();
    dack = 1'b0;
    bubble();
    chk("race_dreq_drop", {31'd0, dreq}, 32'd0);

    // 6: reset mid-transaction, late dack ignored
    drive(1'b1, 32'h500, 32'h0, 32'h1018, 5'd12, 1'b1, 1'b0, 1'b1);
    tick(); tick();
    reset = 1'b1;
    bubble();
    tick();
    reset = 1'b0;
    chk("mr_dreq",   {31'd0, dreq},      32'd0);
    chk("mr_validW", {31'd0, validW},    32'd0);
    chk("mr_result", resultW,            32'd0);
    chk("mr_pcW",    pcW,                32'd0);
    chk("mr_wr",     {27'd0, writeRegW}, 32'd0);
    chk("mr_err",    {31'd0, errW},      32'd0);
    dack = 1'b1; drdata = 32'h55555555;
    tick();
    dack = 1'b0;
    chk("mr_dack_ign", {31'd0, dreq}, 32'd0);
    drive(1'b1, 32'h77, 32'h0, 32'h101C, 5'd1, 1'b1, 1'b0, 1'b0);
    #1 chk("mr_alu_stall", {31'd0, stallM}, 32'd0);
    push(32'h77, 32'h101C, 5'd1, 1'b1, 1'b0);
    tick();
    bubble();
    tick(); tick();

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
